// File: rtl/controller_fsm.sv
// Multicycle control FSM sequencing the CPU datapath: fetch, decode, execute, writeback.
// Optional ILLEGAL_TRAP_EN: undefined instructions trap into a sticky HALT state.
module controller_fsm #(
  parameter int REG_ADD = 4,
  parameter int PSRL    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_ADD-1:0] OP_CODE,
  input  logic [REG_ADD-1:0] OP_EXT,
  input  logic [REG_ADD-1:0] Rdest_addr,
  input  logic [PSRL-1:0]    PSR_OUT,
  output logic               PC_S,
  output logic               MEM_DATA_S,
  output logic               SE_SIGN,
  output logic               REG_WR,
  output logic               MEM_WR,
  output logic [1:0]         MEM_S,
  output logic [1:0]         WD_S,
  output logic [1:0]         ALUA_S,
  output logic [1:0]         ALUB_S,
  output logic               INSTR_EN,
  output logic               ALU_OUT_EN,
  output logic               MEM_REG_EN,
  output logic               PC_EN,
  output logic               PSR_EN,
  output logic [3:0]         state,
  output logic               illegal
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_FETCH2 = 4'd1,  S_DECODE = 4'd2,  S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,  S_WB_ALU = 4'd5,  S_WB_MOV = 4'd6,  S_WB_IMM = 4'd7,
    S_LD1    = 4'd8,  S_LD2    = 4'd9,  S_LD3    = 4'd10, S_ST     = 4'd11,
    S_BRANCH = 4'd12, S_JUMP   = 4'd13, S_HALT   = 4'd14
  } state_t;

  state_t r_state, w_next, w_dispatch;
  logic   w_cond, w_se, w_unused;

  assign w_unused = &{1'b0, PSR_OUT[2:1]};
  assign state    = r_state;

  // PSR bit map: N=4 Z=3 F=2 L=1 C=0
  always_comb begin
    w_cond = 1'b0;
    case (Rdest_addr)
      4'b0000: w_cond = PSR_OUT[3];
      4'b0001: w_cond = ~PSR_OUT[3];
      4'b0010: w_cond = PSR_OUT[0];
      4'b0011: w_cond = ~PSR_OUT[0];
      4'b0110: w_cond = PSR_OUT[4];
      4'b0111: w_cond = ~PSR_OUT[4];
      4'b1110: w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_se = (OP_CODE == 4'b0101) || (OP_CODE == 4'b1001) ||
                (OP_CODE == 4'b1011) || (OP_CODE == 4'b1100);

  always_comb begin
`ifdef ILLEGAL_TRAP_EN
    w_dispatch = S_HALT;
`else
    w_dispatch = S_FETCH;
`endif
    case (OP_CODE)
      4'b0000: case (OP_EXT)
        4'b1101: w_dispatch = S_WB_MOV;
        4'b0101, 4'b1001, 4'b1011,
        4'b0001, 4'b0010, 4'b0011: w_dispatch = S_EXEC_R;
        default: ;
      endcase
      4'b0101, 4'b1001, 4'b1011,
      4'b0001, 4'b0010, 4'b0011: w_dispatch = S_EXEC_I;
      4'b1101: w_dispatch = S_WB_IMM;
      4'b0100: case (OP_EXT)
        4'b0000: w_dispatch = S_LD1;
        4'b0100: w_dispatch = S_ST;
        4'b1100: w_dispatch = S_JUMP;
        default: ;
      endcase
      4'b1100: w_dispatch = S_BRANCH;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Outputs stay at their zero defaults while reset is held low.
  always_comb begin
    w_next     = r_state;
    PC_S       = 1'b0;
    MEM_DATA_S = 1'b0;
    SE_SIGN    = 1'b0;
    REG_WR     = 1'b0;
    MEM_WR     = 1'b0;
    MEM_S      = 2'd0;
    WD_S       = 2'd0;
    ALUA_S     = 2'd0;
    ALUB_S     = 2'd0;
    INSTR_EN   = 1'b0;
    ALU_OUT_EN = 1'b0;
    MEM_REG_EN = 1'b0;
    PC_EN      = 1'b0;
    PSR_EN     = 1'b0;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          MEM_S  = 2'd1;
          w_next = S_FETCH2;
        end
        S_FETCH2: begin
          MEM_S    = 2'd1;
          INSTR_EN = 1'b1;
          ALUA_S   = 2'd1;
          ALUB_S   = 2'd2;
          PC_S     = 1'b1;
          PC_EN    = 1'b1;
          w_next   = S_DECODE;
        end
        S_DECODE: begin
          SE_SIGN = w_se;
          w_next  = w_dispatch;
        end
        S_EXEC_R: begin
          ALU_OUT_EN = 1'b1;
          PSR_EN     = 1'b1;
          w_next     = (OP_EXT == 4'b1011) ? S_FETCH : S_WB_ALU;
        end
        S_EXEC_I: begin
          SE_SIGN    = w_se;
          ALUA_S     = 2'd2;
          ALU_OUT_EN = 1'b1;
          PSR_EN     = 1'b1;
          w_next     = (OP_CODE == 4'b1011) ? S_FETCH : S_WB_ALU;
        end
        S_WB_ALU: begin WD_S = 2'd3; REG_WR = 1'b1; w_next = S_FETCH; end
        S_WB_MOV: begin WD_S = 2'd1; REG_WR = 1'b1; w_next = S_FETCH; end
        S_WB_IMM: begin WD_S = 2'd0; REG_WR = 1'b1; w_next = S_FETCH; end
        S_LD1:    w_next = S_LD2;
        S_LD2: begin MEM_REG_EN = 1'b1; w_next = S_LD3; end
        S_LD3: begin WD_S = 2'd2; REG_WR = 1'b1; w_next = S_FETCH; end
        S_ST:  begin MEM_WR = 1'b1; w_next = S_FETCH; end
        S_BRANCH: begin
          SE_SIGN = w_se;
          ALUA_S  = 2'd1;
          ALUB_S  = 2'd1;
          PC_S    = 1'b1;
          PC_EN   = w_cond;
          w_next  = S_FETCH;
        end
        S_JUMP: begin
          PC_EN  = w_cond;
          w_next = S_FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        S_HALT:  w_next = S_HALT;
`endif
        default: w_next = S_FETCH;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_illegal <= 1'b0;
    else if (w_next == S_HALT) r_illegal <= 1'b1;
  end
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_controller_fsm.sv
// Directed bench for controller_fsm: per-instruction vector table plus reset/trap sequences.
module tb_controller_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] OP_CODE, OP_EXT, Rdest_addr;
  logic [4:0] PSR_OUT;
  logic       PC_S, MEM_DATA_S, SE_SIGN, REG_WR, MEM_WR;
  logic [1:0] MEM_S, WD_S, ALUA_S, ALUB_S;
  logic       INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN;
  logic [3:0] state;
  logic       illegal;
  logic [17:0] outs;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_FETCH2 = 4'd1, ST_DECODE = 4'd2,
                         ST_EXEC_R = 4'd3, ST_EXEC_I = 4'd4, ST_WB_ALU = 4'd5,
                         ST_LD2 = 4'd9, ST_HALT = 4'd14;

  controller_fsm dut (
    .clk(clk), .reset(reset), .OP_CODE(OP_CODE), .OP_EXT(OP_EXT),
    .Rdest_addr(Rdest_addr), .PSR_OUT(PSR_OUT), .PC_S(PC_S), .MEM_DATA_S(MEM_DATA_S),
    .SE_SIGN(SE_SIGN), .REG_WR(REG_WR), .MEM_WR(MEM_WR), .MEM_S(MEM_S), .WD_S(WD_S),
    .ALUA_S(ALUA_S), .ALUB_S(ALUB_S), .INSTR_EN(INSTR_EN), .ALU_OUT_EN(ALU_OUT_EN),
    .MEM_REG_EN(MEM_REG_EN), .PC_EN(PC_EN), .PSR_EN(PSR_EN), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign outs = {PC_S, MEM_DATA_S, SE_SIGN, REG_WR, MEM_WR, MEM_S, WD_S, ALUA_S, ALUB_S,
                 INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN};

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [4:0]  psr;
    int          cyc;
    int          regwr;
    logic [1:0]  wd;
    int          memwr;
    int          psren;
    int          aluen;
    int          memregen;
    int          pcen;
    logic        pcs;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_instr(input logic [15:0] ins, input logic [4:0] psr);
    OP_CODE    = ins[15:12];
    Rdest_addr = ins[11:8];
    OP_EXT     = ins[7:4];
    PSR_OUT    = psr;
  endtask

  // Runs one instruction starting in FETCH; tallies strobes until the FSM is back in FETCH.
  task automatic run_vec(input vec_t v);
    int cyc = 0, regwr = 0, memwr = 0, psren = 0, aluen = 0, memregen = 0, pcen = 0;
    logic [1:0] wd = 2'd0;
    logic pcs = 1'b0;
    load_instr(v.instr, v.psr);
    do begin
      if (REG_WR) begin regwr++; wd = WD_S; end
      if (MEM_WR) begin
        memwr++;
        chk({v.name, " mem_s"}, 32'(MEM_S), 32'd0);
        chk({v.name, " mem_data_s"}, 32'(MEM_DATA_S), 32'd0);
      end
      if (PSR_EN) psren++;
      if (ALU_OUT_EN) aluen++;
      if (MEM_REG_EN) memregen++;
      if (PC_EN) begin
        pcen++;
        if (state != ST_FETCH2) pcs = PC_S;
      end
      chk({v.name, " instr_en"}, 32'(INSTR_EN), 32'(state == ST_FETCH2));
      chk({v.name, " excl"}, 32'(int'(REG_WR) + int'(MEM_WR) + int'(PSR_EN) <= 1), 32'd1);
      cyc++;
      step();
    end while (state != ST_FETCH && cyc < 20);
    chk({v.name, " cycles"}, 32'(cyc), 32'(v.cyc));
    chk({v.name, " reg_wr"}, 32'(regwr), 32'(v.regwr));
    if (v.regwr > 0) chk({v.name, " wd_s"}, 32'(wd), 32'(v.wd));
    chk({v.name, " mem_wr"}, 32'(memwr), 32'(v.memwr));
    chk({v.name, " psr_en"}, 32'(psren), 32'(v.psren));
    chk({v.name, " alu_out_en"}, 32'(aluen), 32'(v.aluen));
    chk({v.name, " mem_reg_en"}, 32'(memregen), 32'(v.memregen));
    chk({v.name, " pc_en"}, 32'(pcen), 32'(v.pcen));
    if (v.pcen > 1) chk({v.name, " pc_s"}, 32'(pcs), 32'(v.pcs));
  endtask

  task automatic se_test(input string name, input logic [15:0] ins, input logic exp);
    load_instr(ins, 5'd0);
    step(); step();
    chk({name, " decode state"}, 32'(state), 32'(ST_DECODE));
    chk({name, " se decode"}, 32'(SE_SIGN), 32'(exp));
    step();
    chk({name, " exec_i state"}, 32'(state), 32'(ST_EXEC_I));
    chk({name, " se exec"}, 32'(SE_SIGN), 32'(exp));
    step(); step();
    chk({name, " back fetch"}, 32'(state), 32'(ST_FETCH));
  endtask

  initial begin
    int seq[5];
    int n;
    logic saw_wr;

    //            name     instr     psr       cyc rw wd mw ps al mr pc pcs
    vecs[0]  = '{"ADD",    16'h0152, 5'b00000, 5, 1, 3, 0, 1, 1, 0, 1, 0};
    vecs[1]  = '{"CMP",    16'h01B2, 5'b00000, 4, 0, 0, 0, 1, 1, 0, 1, 0};
    vecs[2]  = '{"MOV",    16'h01D2, 5'b00000, 4, 1, 1, 0, 0, 0, 0, 1, 0};
    vecs[3]  = '{"ADDI",   16'h5105, 5'b00000, 5, 1, 3, 0, 1, 1, 0, 1, 0};
    vecs[4]  = '{"XORI",   16'h3105, 5'b00000, 5, 1, 3, 0, 1, 1, 0, 1, 0};
    vecs[5]  = '{"CMPI",   16'hB105, 5'b00000, 4, 0, 0, 0, 1, 1, 0, 1, 0};
    vecs[6]  = '{"MOVI",   16'hD105, 5'b00000, 4, 1, 0, 0, 0, 0, 0, 1, 0};
    vecs[7]  = '{"LOAD",   16'h4102, 5'b00000, 6, 1, 2, 0, 0, 0, 1, 1, 0};
    vecs[8]  = '{"STOR",   16'h4143, 5'b00000, 4, 0, 0, 1, 0, 0, 0, 1, 0};
    vecs[9]  = '{"BEQ_t",  16'hC005, 5'b01000, 4, 0, 0, 0, 0, 0, 0, 2, 1};
    vecs[10] = '{"BEQ_n",  16'hC005, 5'b00000, 4, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[11] = '{"BNE_t",  16'hC105, 5'b00000, 4, 0, 0, 0, 0, 0, 0, 2, 1};
    vecs[12] = '{"BCS_t",  16'hC205, 5'b00001, 4, 0, 0, 0, 0, 0, 0, 2, 1};
    vecs[13] = '{"BN_t",   16'hC605, 5'b10000, 4, 0, 0, 0, 0, 0, 0, 2, 1};
    vecs[14] = '{"BNN_n",  16'hC705, 5'b10000, 4, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[15] = '{"BNEVER", 16'hC405, 5'b11111, 4, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[16] = '{"BUC",    16'hCE05, 5'b00000, 4, 0, 0, 0, 0, 0, 0, 2, 1};
    vecs[17] = '{"JUC",    16'h4EC3, 5'b00000, 4, 0, 0, 0, 0, 0, 0, 2, 0};
    vecs[18] = '{"JNE_n",  16'h41C3, 5'b01000, 4, 0, 0, 0, 0, 0, 0, 1, 0};

    reset = 1'b0;
    load_instr(16'h0152, 5'b11111);
    step(); step();
    chk("reset outs", 32'(outs), 32'd0);
    chk("reset state", 32'(state), 32'(ST_FETCH));
    chk("reset illegal", 32'(illegal), 32'd0);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("fetch mem_s", 32'(MEM_S), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    seq = '{0, 1, 2, 3, 5};
    load_instr(16'h0152, 5'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("add seq %0d", i), 32'(state), 32'(seq[i]));
      if (state == ST_WB_ALU) begin
        chk("add wb reg_wr", 32'(REG_WR), 32'd1);
        chk("add wb wd_s", 32'(WD_S), 32'd3);
      end
      step();
    end
    chk("add seq end", 32'(state), 32'(ST_FETCH));

    se_test("ANDI", 16'h11FF, 1'b0);
    se_test("ADDI", 16'h51FF, 1'b1);

    // Abort a load in LD2 with an asynchronous reset pulse.
    load_instr(16'h4102, 5'd0);
    saw_wr = 1'b0;
    n = 0;
    while (state != ST_LD2 && n < 10) begin step(); n++; end
    chk("reach ld2", 32'(state), 32'(ST_LD2));
    #2 reset = 1'b0;
    #1;
    chk("abort state", 32'(state), 32'(ST_FETCH));
    chk("abort outs", 32'(outs), 32'd0);
    saw_wr = saw_wr | REG_WR;
    step();
    saw_wr = saw_wr | REG_WR;
    @(negedge clk) reset = 1'b1;
    #1;
    saw_wr = saw_wr | REG_WR;
    chk("post release fetch", 32'(state), 32'(ST_FETCH));
    step();
    saw_wr = saw_wr | REG_WR;
    chk("post release fetch2", 32'(state), 32'(ST_FETCH2));
    chk("aborted no reg_wr", 32'(saw_wr), 32'd0);
    n = 0;
    while (state != ST_FETCH && n < 10) begin step(); n++; end
    chk("reload done", 32'(state), 32'(ST_FETCH));

    // Undefined opcode 0xF000.
    load_instr(16'hF000, 5'd0);
    step(); step(); step();
`ifdef ILLEGAL_TRAP_EN
    chk("trap halt", 32'(state), 32'(ST_HALT));
    chk("trap illegal", 32'(illegal), 32'd1);
    chk("trap outs", 32'(outs), 32'd0);
    step(); step(); step();
    chk("trap stays", 32'(state), 32'(ST_HALT));
    chk("trap sticky", 32'(illegal), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("trap cleared", 32'(illegal), 32'd0);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("trap fetch", 32'(state), 32'(ST_FETCH));
`else
    chk("nop fetch", 32'(state), 32'(ST_FETCH));
    chk("nop illegal", 32'(illegal), 32'd0);
    run_vec('{"BAD_R", 16'h01F2, 5'b00000, 3, 0, 0, 0, 0, 0, 0, 1, 0});
`endif
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
